// File: rtl/serial_slt_pkg.sv
// Shared definitions for the bit-serial set-less-than comparator.
package serial_slt_pkg;

    // Default operand width used when the top is instantiated without override.
    localparam int DEFAULT_WIDTH = 32;

    // Comparator sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/slt_bit_decide.sv
// Per-bit decision for the MSB-first serial compare.
// When the scanned bits differ, the smaller operand is the one holding 0,
// so lt follows b. For a signed compare the MSB is the sign bit and the
// sense flips: the operand holding 1 is negative, so lt follows a.
module slt_bit_decide
    import serial_slt_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_signed,
    input  logic is_msb,
    output logic differ,
    output logic lt_bit
);

    assign differ = a_bit ^ b_bit;
    assign lt_bit = (is_signed && is_msb) ? a_bit : b_bit;

endmodule

// File: rtl/serial_slt.sv
// Bit-serial a < b / a == b comparator.
// Operands are captured on an accepted start and scanned one bit per cycle
// from the MSB down; the first differing bit decides the result, so the
// latency depends on the data. fsm_state mirrors the FSM for observation.
//
// Handshake: start is a request sampled only while idle (busy=0, done=0);
// it is not held or queued. done is a one-cycle pulse that marks lt/eq as
// valid; lt/eq then hold until the next accepted start.
module serial_slt
    import serial_slt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic [1:0]       fsm_state
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IW-1:0]    index;
    logic             lt_q;
    logic             eq_q;

    logic             differ;
    logic             lt_bit;
    logic             is_msb;

    assign is_msb = (index == MSB_IDX);

    slt_bit_decide u_decide (
        .a_bit     (a_q[index]),
        .b_bit     (b_q[index]),
        .is_signed (signed_q),
        .is_msb    (is_msb),
        .differ    (differ),
        .lt_bit    (lt_bit)
    );

    // Sequencer: capture, MSB-first scan with early exit, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            index    <= MSB_IDX;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= is_signed;
                        index    <= MSB_IDX;
                        lt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (differ) begin
                        lt_q  <= lt_bit;
                        eq_q  <= 1'b0;
                        state <= DONE;
                    end else if (index != '0) begin
                        index <= index - 1'b1;
                    end else begin
                        lt_q  <= 1'b0;
                        eq_q  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == SCAN);
    assign done      = (state == DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_slt.sv
// Self-checking bench for serial_slt: directed corner cases plus random
// operands, checked by a scoreboard fed from a behavioural model.
module tb_serial_slt;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic [1:0]   fsm_state;

    always #5 clk = ~clk;

    serial_slt #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .eq        (eq),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        lt;
        logic        eq;
        logic [7:0]  lat;
        logic [31:0] scyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // Reference model: plain comparison operators for the result; latency is
    // the position of the most significant differing bit counted from the MSB,
    // plus the cycle in which DONE is shown.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int sc);
        exp_t r;
        int msb;
        int n;
        logic [W-1:0] d;
        d   = x ^ y;
        msb = -1;
        for (int i = 0; i < W; i++) if (d[i]) msb = i;
        n = (msb < 0) ? W : (W - msb);
        r.eq   = (x == y);
        r.lt   = s ? ($signed(x) < $signed(y)) : (x < y);
        r.lat  = 8'(n + 1);
        r.scyc = 32'(sc);
        return r;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    logic prev_done = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("lt", {31'd0, lt}, {31'd0, e.lt});
                    check("eq", {31'd0, eq}, {31'd0, e.eq});
                    check("latency", 32'(cycle) - e.scyc, {24'd0, e.lat});
                end
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        wait_idle();
        @(negedge clk);
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        exp_q.push_back(model(x, y, s, cycle));
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after capture; the running result must not change.
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int mode;

        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_lt",    {31'd0, lt},   32'd0);
        check("rst_eq",    {31'd0, eq},   32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        reset_n = 1'b1;

        // Directed corner cases.
        start_op(32'd5, 32'd7, 1'b0);
        start_op(32'hFFFF_FFFF, 32'd1, 1'b1);
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        start_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        start_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_idle();
        repeat (5) begin
            @(negedge clk);
            check("hold_lt",   {31'd0, lt},   32'd0);
            check("hold_eq",   {31'd0, eq},   32'd1);
            check("hold_done", {31'd0, done}, 32'd0);
        end

        // Start pulsed during SCAN and during DONE is ignored.
        start_op(32'd3, 32'd2, 1'b0);
        repeat (5) @(negedge clk);
        a = 32'd0; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && busy) @(negedge clk);
        a = 32'd0; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored_start_busy", {31'd0, busy}, 32'd0);
        check("ignored_start_lt",   {31'd0, lt},   32'd0);

        // Reset in the middle of a scan.
        start_op(32'd0, 32'd1, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_lt",   {31'd0, lt},   32'd0);
        check("midrst_eq",   {31'd0, eq},   32'd0);
        reset_n = 1'b1;
        start_op(32'd1, 32'd2, 1'b0);

        // Reset has priority over a simultaneous start.
        wait_idle();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b1;
        a = 32'd1;
        b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        reset_n = 1'b1;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_prio_idle", {31'd0, busy}, 32'd0);

        // Random operands with varied depth of the deciding bit.
        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 3);
            x = $urandom;
            case (mode)
                0: y = $urandom;
                1: y = x ^ (32'h1 << $urandom_range(0, W - 1));
                2: y = x;
                default: y = x ^ 32'h8000_0000;
            endcase
            start_op(x, y, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
